// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: 3-bit state encoding,
// the state type and the default counter width.
package rst_seq_pkg;

    localparam logic [2:0] ENC_ASSERT    = 3'd0;
    localparam logic [2:0] ENC_REL_PHY   = 3'd1;
    localparam logic [2:0] ENC_WAIT_CORE = 3'd2;
    localparam logic [2:0] ENC_WAIT_USER = 3'd3;
    localparam logic [2:0] ENC_RUN       = 3'd4;
    localparam logic [2:0] ENC_ERR       = 3'd5;

    typedef enum logic [2:0] {
        ST_ASSERT    = ENC_ASSERT,
        ST_REL_PHY   = ENC_REL_PHY,
        ST_WAIT_CORE = ENC_WAIT_CORE,
        ST_WAIT_USER = ENC_WAIT_USER,
        ST_RUN       = ENC_RUN,
        ST_ERR       = ENC_ERR
    } state_t;

    localparam int unsigned CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/rst_seq_cnt.sv
// Clear/enable saturating up-counter with a terminal-compare flag.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr        - clear to zero (wins over en)
//   en         - count up by one, holding at all-ones
//   term       - terminal value to compare against
//   term_hit_c - combinational: count equals term
module rst_seq_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             term_hit_c
);

    logic [WIDTH-1:0] count;

    // Saturating counter; never wraps past all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign term_hit_c = (count == term);

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release: PHY, then core, then user, gated on lock_in.
// Optional lock timeout enabled by macro RST_SEQ_LOCK_TIMEOUT_EN.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rst_req_in    - debounced reset request (active level REQ_ACTIVE)
//   lock_in       - PLL/link lock
//   phy_rst_out, core_rst_out, user_rst_out - active-high resets
//   seq_done      - all resets released
//   seq_err       - sticky lock-timeout flag (0 without the macro)
//   state_out     - current state encoding
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter logic        REQ_ACTIVE   = 1'b0,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned STAGE_DELAY  = 8,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_req_in,
    input  logic       lock_in,
    output logic       phy_rst_out,
    output logic       core_rst_out,
    output logic       user_rst_out,
    output logic       seq_done,
    output logic       seq_err,
    output logic [2:0] state_out
);

    state_t               state;
    logic                 req_c;
    logic                 cnt_clr_c;
    logic                 cnt_en_c;
    logic                 term_hit_c;
    logic [CNT_WIDTH-1:0] term_c;

    assign req_c = (rst_req_in == REQ_ACTIVE);

    // Counter control: clear on every state exit, count while dwelling.
    always_comb begin
        cnt_clr_c = 1'b0;
        cnt_en_c  = 1'b0;
        term_c    = CNT_WIDTH'(HOLD_CYCLES - 1);
        case (state)
            ST_ASSERT: begin
                if (req_c || term_hit_c) cnt_clr_c = 1'b1;
                else                     cnt_en_c  = 1'b1;
            end
            ST_REL_PHY: begin
                term_c = CNT_WIDTH'(LOCK_TIMEOUT - 1);
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
                if (req_c || lock_in || term_hit_c) cnt_clr_c = 1'b1;
                else                                cnt_en_c  = 1'b1;
`else
                cnt_clr_c = 1'b1;
`endif
            end
            ST_WAIT_CORE, ST_WAIT_USER: begin
                term_c = CNT_WIDTH'(STAGE_DELAY - 1);
                if (req_c || !lock_in || term_hit_c) cnt_clr_c = 1'b1;
                else                                 cnt_en_c  = 1'b1;
            end
            ST_ERR: begin
                if (req_c || term_hit_c) cnt_clr_c = 1'b1;
                else                     cnt_en_c  = 1'b1;
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

    rst_seq_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr_c),
        .en         (cnt_en_c),
        .term       (term_c),
        .term_hit_c (term_hit_c)
    );

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
    logic err_q;
    assign seq_err = err_q;
`else
    assign seq_err = 1'b0;
`endif

    // State and registered outputs; priority rst > request > lock loss > terminal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_ASSERT;
            phy_rst_out  <= 1'b1;
            core_rst_out <= 1'b1;
            user_rst_out <= 1'b1;
            seq_done     <= 1'b0;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else if (req_c && (state != ST_ASSERT)) begin
            state        <= ST_ASSERT;
            phy_rst_out  <= 1'b1;
            core_rst_out <= 1'b1;
            user_rst_out <= 1'b1;
            seq_done     <= 1'b0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (!req_c && term_hit_c) begin
                        state       <= ST_REL_PHY;
                        phy_rst_out <= 1'b0;
                    end
                end
                ST_REL_PHY: begin
                    if (lock_in) begin
                        state <= ST_WAIT_CORE;
                    end
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
                    else if (term_hit_c) begin
                        state       <= ST_ERR;
                        phy_rst_out <= 1'b1;
                        err_q       <= 1'b1;
                    end
`endif
                end
                ST_WAIT_CORE, ST_WAIT_USER, ST_RUN: begin
                    if (!lock_in) begin
                        state        <= ST_ASSERT;
                        phy_rst_out  <= 1'b1;
                        core_rst_out <= 1'b1;
                        user_rst_out <= 1'b1;
                        seq_done     <= 1'b0;
                    end else if (state == ST_WAIT_CORE && term_hit_c) begin
                        state        <= ST_WAIT_USER;
                        core_rst_out <= 1'b0;
                    end else if (state == ST_WAIT_USER && term_hit_c) begin
                        state        <= ST_RUN;
                        user_rst_out <= 1'b0;
                        seq_done     <= 1'b1;
`ifdef RST_SEQ_LOCK_TIMEOUT_EN
                        err_q        <= 1'b0;
`endif
                    end
                end
                ST_ERR: begin
                    // Resets are already all asserted; just wait out the hold.
                    if (term_hit_c) begin
                        state <= ST_ASSERT;
                    end
                end
                default: begin
                    state        <= ST_ASSERT;
                    phy_rst_out  <= 1'b1;
                    core_rst_out <= 1'b1;
                    user_rst_out <= 1'b1;
                    seq_done     <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumes the debounced, synchronised reset request (for example PERST# or a push button) from the debounce stage.
- Produces a staged, ordered release of PHY, core and user resets, gated on a PLL/link lock indication.
- Sits between the board-level debounce and the PCIe hard IP / user logic reset inputs; all outputs are registered in the `clk` domain.

Parameters:
- REQ_ACTIVE, 0, active level of rst_req_in (0 = active-low request).
- HOLD_CYCLES, 16, minimum cycles all resets stay asserted after the request goes inactive; must be >= 2.
- STAGE_DELAY, 8, cycles between lock seen and core release, and between core release and user release; must be >= 1.
- LOCK_TIMEOUT, 1024, cycles to wait for lock_in after PHY release (optional feature only).
- CNT_WIDTH, 16, counter width; must hold max(HOLD_CYCLES, STAGE_DELAY, LOCK_TIMEOUT).

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- rst_req_in, input, 1, debounced reset request, already synchronous to clk.
- lock_in, input, 1, PLL/link lock, synchronous to clk.
- phy_rst_out, output, 1, active-high PHY reset.
- core_rst_out, output, 1, active-high core reset.
- user_rst_out, output, 1, active-high user reset.
- seq_done, output, 1, high while all resets are released.
- seq_err, output, 1, sticky lock-timeout flag.
- state_out, output, 3, current FSM state encoding for debug.

Behaviour:
- Reset (rst=1, synchronous): state=ASSERT, counter=0, phy/core/user_rst_out=1, seq_done=0, seq_err=0.
- All outputs are registered and change on the same edge as the state transition that causes them.
- States: ASSERT, REL_PHY, WAIT_CORE, WAIT_USER, RUN, ERR.
- ASSERT: all three resets = 1.
  - Counter clears while the request is active; otherwise it increments.
  - At counter==HOLD_CYCLES-1 with request inactive -> REL_PHY; phy_rst_out=0 on that edge; counter=0.
- REL_PHY: lock_in=1 -> WAIT_CORE, counter=0. Otherwise wait (see Optional Feature).
- WAIT_CORE: counter increments. At STAGE_DELAY-1 -> WAIT_USER; core_rst_out=0; counter=0.
- WAIT_USER: counter increments. At STAGE_DELAY-1 -> RUN; user_rst_out=0; seq_done=1; seq_err cleared.
- RUN: holds, counter idle.
- Request active (rst_req_in==REQ_ACTIVE) in any state except ASSERT:
  - next edge -> ASSERT, all resets=1, seq_done=0, counter=0.
- lock_in=0 in WAIT_CORE, WAIT_USER or RUN -> ASSERT with the same effect as a request.
- Event priority: rst > request > lock loss > counter terminal.
- Reset release order is strictly phy -> core -> user. Assertion is simultaneous for all three.
- Counter saturates and never wraps.
- A request pulse of a single cycle restarts the full sequence, including the full HOLD_CYCLES.
- State encoding:
  - ASSERT=0
  - REL_PHY=1
  - WAIT_CORE=2
  - WAIT_USER=3
  - RUN=4
  - ERR=5

Optional Feature:
- Macro RST_SEQ_LOCK_TIMEOUT_EN.
- Defined:
  - In REL_PHY the counter increments. At LOCK_TIMEOUT-1 without lock -> ERR.
  - Entering ERR sets phy_rst_out=1 and seq_err=1 (sticky). ERR holds all resets asserted for HOLD_CYCLES, then -> ASSERT and retries.
  - A request in ERR -> ASSERT immediately.
- Undefined: REL_PHY waits indefinitely, ERR is unreachable, and seq_err is tied 0.

Decomposition:
- Package rst_seq_pkg holds:
  - state encoding constants (3-bit);
  - the state typedef;
  - the counter width default.
- One natural sub-module, rst_seq_cnt: a clear/enable saturating up-counter with a terminal-compare output, instantiated once and shared by all states.

Test Plan:
- Defaults, lock_in=1, request inactive, rst released at edge 0: phy_rst_out falls at edge 16, core_rst_out at edge 25, user_rst_out and seq_done at edge 33.
- Request active for 1 cycle while in RUN: all resets =1 on the next edge, seq_done=0, and the full sequence repeats with 16/9/8-cycle spacing.
- lock_in held 0 for 40 cycles after phy release: core_rst_out stays 1. Raising lock_in produces core release 9 edges later.
- lock_in drops during WAIT_USER: all resets reasserted on the next edge, state_out=0.
- Request held active for 100 cycles: counter stays 0 and resets stay asserted. After release, phy releases exactly 16 edges later.
- With RST_SEQ_LOCK_TIMEOUT_EN, lock_in=0 permanently:
  - at edge 16+1024: seq_err=1, phy_rst_out=1, state_out=5;
  - 16 edges later: state_out=0 and the retry begins;
  - on a later successful lock, seq_err clears when seq_done rises.
